ex_hazard_ctrl: RTL and testbench

EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

---
 rtl/ex_hazard_ctrl_pkg.sv | 16 +
 rtl/ex_hazard_ctrl_sat_counter.sv | 26 ++
 rtl/ex_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types and constants for the EX-stage hazard controller.
package ex_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam int MEM_RD = 1;
    localparam int MEM_WR = 0;

    localparam int CNT_W_DEF      = 16;
    localparam int MD_MAX_CYC_DEF = 34;

endpackage

// File: rtl/ex_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Pipeline hazard control: cache stalls, branch mispredict flush, load-use
// stalls and multi-cycle MUL/DIV hold, with saturating performance counters.
module ex_hazard_ctrl
    import ex_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MD_MAX_CYC = MD_MAX_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ICache_stall,
    input  logic             DCache_stall,
    input  logic [1:0]       Mem_2,
    input  logic [4:0]       Rd_2,
    input  logic [4:0]       Rs1_1,
    input  logic [4:0]       Rs2_1,
    input  logic             md_start_2,
    input  logic             md_done,
    input  logic             is_branchInst_3,
    input  logic             taken_3,
    input  logic             prev_taken_3,
    input  logic [7:0]       target_3,
    output logic             memory_stall,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             flush_ID,
    output logic             bubble_EX,
    output logic             hold_EX,
    output logic             md_busy,
    output logic             redirect_valid,
    output logic [7:0]       redirect_PC,
    output logic             md_timeout,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MCW = $clog2(MD_MAX_CYC + 1);

    state_e         r_state;
    logic           r_ret_md;
    logic [MCW-1:0] r_md_cnt;
    logic           r_md_timeout;

    state_e w_state;
    logic   w_active;
    logic   w_mem_stall;
    logic   w_mispredict;
    logic   w_load_use;
    logic   w_in_md;
    logic   w_hold;
    logic   w_stall_inc;
    logic   w_unused_memwr;

    assign w_active     = ~rst;
    assign w_mem_stall  = (ICache_stall | DCache_stall) & w_active;
    assign w_mispredict = w_active & ~w_mem_stall & is_branchInst_3 & (taken_3 ^ prev_taken_3);

    // Once both stalls clear, MEM_WAIT behaves as its return state in that same cycle.
    assign w_state = (r_state == MEM_WAIT && !w_mem_stall) ? (r_ret_md ? MD_WAIT : RUN) : r_state;
    assign w_in_md = (r_state == MD_WAIT) || (r_state == MEM_WAIT && r_ret_md);

    assign w_load_use = w_active & ~w_mem_stall & ~w_mispredict & ~md_start_2 &
                        (w_state == RUN) & Mem_2[MEM_RD] & (Rd_2 != 5'd0) &
                        ((Rd_2 == Rs1_1) | (Rd_2 == Rs2_1));

    assign w_hold         = w_active & ~w_mem_stall & (w_state == MD_WAIT);
    assign w_unused_memwr = Mem_2[MEM_WR];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= RUN;
            r_ret_md     <= 1'b0;
            r_md_cnt     <= '0;
            r_md_timeout <= 1'b0;
        end else if (w_mem_stall) begin
            r_state  <= MEM_WAIT;
            // A md_done that lands during the stall is folded in so the lost pulse does not strand MD_WAIT.
            r_ret_md <= w_in_md & ~md_done;
        end else begin
            case (w_state)
                RUN: begin
                    if (!w_mispredict && md_start_2 && !md_done) begin
                        r_state  <= MD_WAIT;
                        r_md_cnt <= MCW'(1);
                    end else begin
                        r_state  <= RUN;
                        r_md_cnt <= '0;
                    end
                end
                MD_WAIT: begin
                    if (md_done) begin
                        r_state  <= RUN;
                        r_md_cnt <= '0;
                    end else if (r_md_cnt >= MCW'(MD_MAX_CYC)) begin
                        r_state      <= RUN;
                        r_md_cnt     <= '0;
                        r_md_timeout <= 1'b1;
                    end else begin
                        r_state  <= MD_WAIT;
                        r_md_cnt <= r_md_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= RUN;
                    r_md_cnt <= '0;
                end
            endcase
        end
    end

    assign memory_stall   = w_mem_stall;
    assign hold_EX        = w_hold;
    assign stall_IF       = w_load_use | w_hold;
    assign stall_ID       = w_load_use | w_hold;
    assign flush_ID       = w_mispredict;
    assign bubble_EX      = w_mispredict | w_load_use;
    assign md_busy        = w_active & w_in_md;
    assign redirect_valid = w_mispredict;
    assign redirect_PC    = w_mispredict ? target_3 : '0;
    assign md_timeout     = r_md_timeout;

    assign w_stall_inc = w_mem_stall | stall_IF | w_hold;

    sat_counter #(.W(CNT_W)) u_mispredict_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_mispredict),
        .clear (1'b0),
        .count (mispredict_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .clear (1'b0),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: per-cycle control expectations queued at drive time.
module tb_ex_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       ICache_stall, DCache_stall;
    logic [1:0] Mem_2;
    logic [4:0] Rd_2, Rs1_1, Rs2_1;
    logic       md_start_2, md_done;
    logic       is_branchInst_3, taken_3, prev_taken_3;
    logic [7:0] target_3;
    logic       memory_stall, stall_IF, stall_ID, flush_ID, bubble_EX, hold_EX;
    logic       md_busy, redirect_valid, md_timeout;
    logic [7:0] redirect_PC;
    logic [3:0] mispredict_cnt, stall_cnt;

    ex_hazard_ctrl #(.CNT_W(4), .MD_MAX_CYC(34)) dut (
        .clk             (clk),
        .rst             (rst),
        .ICache_stall    (ICache_stall),
        .DCache_stall    (DCache_stall),
        .Mem_2           (Mem_2),
        .Rd_2            (Rd_2),
        .Rs1_1           (Rs1_1),
        .Rs2_1           (Rs2_1),
        .md_start_2      (md_start_2),
        .md_done         (md_done),
        .is_branchInst_3 (is_branchInst_3),
        .taken_3         (taken_3),
        .prev_taken_3    (prev_taken_3),
        .target_3        (target_3),
        .memory_stall    (memory_stall),
        .stall_IF        (stall_IF),
        .stall_ID        (stall_ID),
        .flush_ID        (flush_ID),
        .bubble_EX       (bubble_EX),
        .hold_EX         (hold_EX),
        .md_busy         (md_busy),
        .redirect_valid  (redirect_valid),
        .redirect_PC     (redirect_PC),
        .md_timeout      (md_timeout),
        .mispredict_cnt  (mispredict_cnt),
        .stall_cnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ic, dc;
        logic [1:0] mem;
        logic [4:0] rd, rs1, rs2;
        logic       mds, mdd, br, tk, ptk;
        logic [7:0] tgt;
    } stim_t;

    typedef struct {
        string       name;
        logic [16:0] ctrl;
    } exp_t;

    exp_t        q[$];
    logic [16:0] cur_exp;
    logic [3:0]  m_stall, m_mp;
    int          checks = 0;
    int          errors = 0;

    // Packing order: memory_stall, stall_IF, stall_ID, flush_ID, bubble_EX, hold_EX, md_busy, redirect_valid, redirect_PC, md_timeout
    function automatic logic [16:0] E(input logic ms, sif, sid, fl, bub, hold, busy, rv,
                                      input logic [7:0] pc, input logic to);
        return {ms, sif, sid, fl, bub, hold, busy, rv, pc, to};
    endfunction

    function automatic stim_t S(input logic ic, dc, input logic [1:0] mem,
                                input logic [4:0] rd, rs1, rs2,
                                input logic mds, mdd, br, tk, ptk, input logic [7:0] tgt);
        return {ic, dc, mem, rd, rs1, rs2, mds, mdd, br, tk, ptk, tgt};
    endfunction

    function automatic logic [16:0] obs();
        return {memory_stall, stall_IF, stall_ID, flush_ID, bubble_EX, hold_EX,
                md_busy, redirect_valid, redirect_PC, md_timeout};
    endfunction

    // Counter reference driven by the bench's own per-cycle expectations.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_stall <= 4'd0;
            m_mp    <= 4'd0;
        end else begin
            if ((cur_exp[16] | cur_exp[15] | cur_exp[11]) && m_stall != 4'hF) m_stall <= m_stall + 4'd1;
            if (cur_exp[9] && m_mp != 4'hF) m_mp <= m_mp + 4'd1;
        end
    end

    task automatic apply(input stim_t s);
        {ICache_stall, DCache_stall, Mem_2, Rd_2, Rs1_1, Rs2_1, md_start_2, md_done,
         is_branchInst_3, taken_3, prev_taken_3, target_3} = s;
    endtask

    task automatic cyc(input string nm, input stim_t s, input logic [16:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        apply(s);
        cur_exp = e;
        x.name = nm;
        x.ctrl = e;
        q.push_back(x);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cur_exp = '0;
        apply(S(0, 1, 2'b10, 5, 5, 0, 1, 0, 1, 1, 0, 8'h40));
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs() !== 17'h0) begin
            errors++;
            $display("FAIL reset_ctrl got %05h exp %05h", obs(), 17'h0);
        end
        checks++;
        if ({stall_cnt, mispredict_cnt} !== 8'h00) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt, mispredict_cnt);
        end
        apply('0);
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        stim_t st[$];
        logic [16:0] ex[$];
        exp_t e;
        st.push_back(S(0, 0, 2'b10, 5, 5, 0, 0, 0, 0, 0, 0, 0));  ex.push_back(E(0,1,1,0,1,0,0,0,0,0));
        st.push_back(S(0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0));  ex.push_back(E(0,0,0,0,0,0,0,0,0,0));
        st.push_back(S(0, 0, 2'b10, 7, 3, 7, 0, 0, 0, 0, 0, 0));  ex.push_back(E(0,1,1,0,1,0,0,0,0,0));
        st.push_back(S(0, 0, 2'b01, 5, 5, 0, 0, 0, 0, 0, 0, 0));  ex.push_back(E(0,0,0,0,0,0,0,0,0,0));
        st.push_back(S(0, 0, 2'b10, 9, 3, 4, 0, 0, 0, 0, 0, 0));  ex.push_back(E(0,0,0,0,0,0,0,0,0,0));
        foreach (st[i]) begin
            cyc("load_use", st[i], ex[i]);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e.ctrl) begin
                errors++;
                $display("FAIL %s[%0d] ctrl got %05h exp %05h", e.name, i, obs(), e.ctrl);
            end
            checks++;
            if ({stall_cnt, mispredict_cnt} !== {m_stall, m_mp}) begin
                errors++;
                $display("FAIL %s[%0d] cnt got %0d/%0d exp %0d/%0d", e.name, i, stall_cnt, mispredict_cnt, m_stall, m_mp);
            end
        end
    endtask

    task automatic test_mispredict();
        stim_t st[$];
        logic [16:0] ex[$];
        exp_t e;
        st.push_back(S(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 8'h40)); ex.push_back(E(0,0,0,1,1,0,0,1,8'h40,0));
        st.push_back(S(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 1, 8'h40)); ex.push_back(E(0,0,0,0,0,0,0,0,8'h00,0));
        st.push_back(S(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 8'h40)); ex.push_back(E(0,0,0,0,0,0,0,0,8'h00,0));
        st.push_back(S(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 8'h80)); ex.push_back(E(0,0,0,1,1,0,0,1,8'h80,0));
        st.push_back(S(0, 0, 2'b10, 5, 5, 0, 0, 0, 1, 1, 0, 8'h22)); ex.push_back(E(0,0,0,1,1,0,0,1,8'h22,0));
        st.push_back(S(0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 1, 0, 8'h33)); ex.push_back(E(0,0,0,1,1,0,0,1,8'h33,0));
        st.push_back(S(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00)); ex.push_back(E(0,0,0,0,0,0,0,0,8'h00,0));
        foreach (st[i]) begin
            cyc("mispredict", st[i], ex[i]);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e.ctrl) begin
                errors++;
                $display("FAIL %s[%0d] ctrl got %05h exp %05h", e.name, i, obs(), e.ctrl);
            end
            checks++;
            if ({stall_cnt, mispredict_cnt} !== {m_stall, m_mp}) begin
                errors++;
                $display("FAIL %s[%0d] cnt got %0d/%0d exp %0d/%0d", e.name, i, stall_cnt, mispredict_cnt, m_stall, m_mp);
            end
        end
    endtask

    task automatic test_md_done();
        stim_t st[$];
        logic [16:0] ex[$];
        exp_t e;
        st.push_back(S(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0,0));
        for (int k = 1; k <= 5; k++) begin
            st.push_back(S(0, 0, 0, 0, 0, 0, 0, (k == 5), 0, 0, 0, 0));
            ex.push_back(E(0,1,1,0,0,1,1,0,0,0));
        end
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0,0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0,0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0,0));
        foreach (st[i]) begin
            cyc("md_done", st[i], ex[i]);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e.ctrl) begin
                errors++;
                $display("FAIL %s[%0d] ctrl got %05h exp %05h", e.name, i, obs(), e.ctrl);
            end
            checks++;
            if ({stall_cnt, mispredict_cnt} !== {m_stall, m_mp}) begin
                errors++;
                $display("FAIL %s[%0d] cnt got %0d/%0d exp %0d/%0d", e.name, i, stall_cnt, mispredict_cnt, m_stall, m_mp);
            end
        end
    endtask

    task automatic test_md_mem_stall();
        stim_t st[$];
        logic [16:0] ex[$];
        exp_t e;
        st.push_back(S(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0,0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0,1,1,0,0,1,1,0,0,0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0,1,1,0,0,1,1,0,0,0));
        for (int k = 0; k < 3; k++) begin
            st.push_back(S(0, 1, 2'b10, 5, 5, 0, 0, 0, 1, 1, 0, 8'h55));
            ex.push_back(E(1,0,0,0,0,0,1,0,0,0));
        end
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0,1,1,0,0,1,1,0,0,0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); ex.push_back(E(0,1,1,0,0,1,1,0,0,0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0,0));
        st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(1,0,0,0,0,0,0,0,0,0));
        st.push_back(S(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(1,0,0,0,0,0,0,0,0,0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0,0));
        foreach (st[i]) begin
            cyc("md_mem_stall", st[i], ex[i]);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e.ctrl) begin
                errors++;
                $display("FAIL %s[%0d] ctrl got %05h exp %05h", e.name, i, obs(), e.ctrl);
            end
            checks++;
            if ({stall_cnt, mispredict_cnt} !== {m_stall, m_mp}) begin
                errors++;
                $display("FAIL %s[%0d] cnt got %0d/%0d exp %0d/%0d", e.name, i, stall_cnt, mispredict_cnt, m_stall, m_mp);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        exp_t e;
        cyc("rst_mid", S(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), E(0,0,0,0,0,0,0,0,0,0));
        @(negedge clk); e = q.pop_front();
        cyc("rst_mid", S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), E(0,1,1,0,0,1,1,0,0,0));
        @(negedge clk); e = q.pop_front();
        checks++;
        if (obs() !== e.ctrl) begin
            errors++;
            $display("FAIL %s md_wait ctrl got %05h exp %05h", e.name, obs(), e.ctrl);
        end
        cyc("rst_mid", S(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 8'h11), E(1,0,0,0,0,0,1,0,0,0));
        @(negedge clk); e = q.pop_front();
        checks++;
        if (obs() !== e.ctrl) begin
            errors++;
            $display("FAIL %s mem_wait ctrl got %05h exp %05h", e.name, obs(), e.ctrl);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs() !== 17'h0) begin
            errors++;
            $display("FAIL rst_mid_async ctrl got %05h exp %05h", obs(), 17'h0);
        end
        checks++;
        if ({stall_cnt, mispredict_cnt} !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_async cnt got %0d/%0d exp 0/0", stall_cnt, mispredict_cnt);
        end
        @(negedge clk);
        cur_exp = '0;
        apply('0);
        rst = 1'b0;
        cyc("rst_mid_after", S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), E(0,0,0,0,0,0,0,0,0,0));
        @(negedge clk); e = q.pop_front();
        checks++;
        if (obs() !== e.ctrl) begin
            errors++;
            $display("FAIL %s ctrl got %05h exp %05h", e.name, obs(), e.ctrl);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        cur_exp = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            cyc("sat", S(0, (k < 20), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                E((k < 20),0,0,0,0,0,0,0,0,0));
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e.ctrl) begin
                errors++;
                $display("FAIL %s[%0d] ctrl got %05h exp %05h", e.name, k, obs(), e.ctrl);
            end
            checks++;
            if (stall_cnt !== m_stall) begin
                errors++;
                $display("FAIL %s[%0d] stall_cnt got %0d exp %0d", e.name, k, stall_cnt, m_stall);
            end
        end
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_final stall_cnt got %0d exp 15", stall_cnt);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        for (int k = 0; k <= 36; k++) begin
            if (k == 0)
                cyc("timeout", S(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), E(0,0,0,0,0,0,0,0,0,0));
            else if (k <= 34)
                cyc("timeout", S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), E(0,1,1,0,0,1,1,0,0,0));
            else
                cyc("timeout", S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), E(0,0,0,0,0,0,0,0,0,1));
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e.ctrl) begin
                errors++;
                $display("FAIL %s[%0d] ctrl got %05h exp %05h", e.name, k, obs(), e.ctrl);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs() !== 17'h0) begin
            errors++;
            $display("FAIL timeout_reset ctrl got %05h exp %05h", obs(), 17'h0);
        end
        @(negedge clk);
        cur_exp = '0;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cur_exp = '0;
        apply('0);
        test_reset();
        test_load_use();
        test_mispredict();
        test_md_done();
        test_md_mem_stall();
        test_reset_mid_stall();
        test_saturation();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
